// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SPI-mode SD card responder.
package sd_resp_pkg;

  typedef enum logic [1:0] {StHunt, StRx, StNcr, StTx} state_e;

  localparam logic [5:0] Cmd0  = 6'd0;
  localparam logic [5:0] Cmd8  = 6'd8;
  localparam logic [5:0] Cmd41 = 6'd41;
  localparam logic [5:0] Cmd55 = 6'd55;
  localparam logic [5:0] Cmd58 = 6'd58;

  localparam int unsigned R1IdleBit    = 0;
  localparam int unsigned R1IllegalBit = 2;
  localparam int unsigned R1CrcErrBit  = 3;

  localparam int unsigned RespR1Bits   = 8;
  localparam int unsigned RespLongBits = 40;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(logic [6:0] crc, logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with clear and shift-enable; used when SD_RESP_CRC_CHECK_EN is defined.
module sd_crc7
  import sd_resp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       shift_en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, base;

  // Clear and shift in the same cycle starts a fresh CRC with din_i as its first bit.
  always_comb begin
    base  = clear_i ? 7'd0 : crc_q;
    crc_d = shift_en_i ? crc7_step(base, din_i) : base;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_q <= 7'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card model: receives 48-bit command frames, answers R1/R3/R7.
// Optional CRC7 command checking is enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_spi_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned NCR_BYTES  = 1,
  parameter int unsigned INIT_POLLS = 2,
  parameter logic [31:0] OCR        = 32'h40FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        in_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  localparam int unsigned NcrBits = 8 * NCR_BYTES;

  logic [2:0]  sclk_sync_q;
  logic [1:0]  cs_sync_q, mosi_sync_q;
  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [45:0] rx_q, rx_d;
  logic [39:0] resp_q, resp_d;
  logic        long_q, long_d;
  logic        idle_q, idle_d, app_q, app_d, miso_q, miso_d, valid_q, valid_d;
  logic [3:0]  polls_q, polls_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;

  logic        rise, fall, cs_active, mosi_s;
  logic [46:0] frame_w;
  logic [5:0]  frame_idx;
  logic [31:0] frame_arg;
  logic        crc_err, crc_clear, crc_shift;

  logic        ex_idle, ex_app, ex_illegal, ex_long;
  logic [3:0]  ex_polls;
  logic [31:0] ex_tail;
  logic [7:0]  ex_r1;

  assign rise      = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall      = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_active = ~cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  // Bits 46..0 of the frame as seen on the end-bit rise.
  assign frame_w   = {rx_q, mosi_s};
  assign frame_idx = frame_w[45:40];
  assign frame_arg = frame_w[39:8];

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] crc_calc;

  sd_crc7 u_crc7 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (crc_clear),
    .shift_en_i(crc_shift),
    .din_i     (mosi_s),
    .crc_o     (crc_calc)
  );

  assign crc_err = (crc_calc != frame_w[7:1]);
`else
  logic unused_crc;
  assign unused_crc = ^{crc_clear, crc_shift, frame_w[7:1]};
  assign crc_err    = 1'b0;
`endif

  // Command execution, applied only when a well-formed frame is accepted.
  always_comb begin
    ex_idle    = idle_q;
    ex_polls   = polls_q;
    ex_app     = 1'b0;
    ex_illegal = 1'b0;
    ex_long    = 1'b0;
    ex_tail    = 32'h0;
    case (frame_idx)
      Cmd0: begin
        ex_idle  = 1'b1;
        ex_polls = 4'd0;
      end
      Cmd8: begin
        ex_long = 1'b1;
        ex_tail = {20'h0, frame_arg[11:0]};
      end
      Cmd55: ex_app = 1'b1;
      Cmd41: begin
        if (app_q) begin
          ex_polls = (polls_q == 4'hF) ? polls_q : polls_q + 4'd1;
          if (32'(ex_polls) >= INIT_POLLS) ex_idle = 1'b0;
        end else begin
          ex_illegal = 1'b1;
        end
      end
      Cmd58: begin
        ex_long = 1'b1;
        ex_tail = {~idle_q, OCR[30:0]};
      end
      default: ex_illegal = 1'b1;
    endcase
    // A corrupted frame is reported but not executed; even the app flag survives.
    if (crc_err) begin
      ex_idle    = idle_q;
      ex_polls   = polls_q;
      ex_app     = app_q;
      ex_illegal = 1'b0;
      ex_long    = 1'b0;
      ex_tail    = 32'h0;
    end
    ex_r1               = 8'h00;
    ex_r1[R1IdleBit]    = ex_idle;
    ex_r1[R1IllegalBit] = ex_illegal;
    ex_r1[R1CrcErrBit]  = crc_err;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    long_d    = long_q;
    idle_d    = idle_q;
    polls_d   = polls_q;
    app_d     = app_q;
    miso_d    = miso_q;
    valid_d   = 1'b0;
    index_d   = index_q;
    arg_d     = arg_q;
    crc_clear = 1'b0;
    crc_shift = 1'b0;
    if (!cs_active) begin
      state_d   = StHunt;
      miso_d    = 1'b1;
      crc_clear = 1'b1;
    end else begin
      unique case (state_q)
        StHunt: begin
          miso_d    = 1'b1;
          crc_clear = 1'b1;
          if (rise && !mosi_s) begin
            state_d   = StRx;
            cnt_d     = 7'd1;
            crc_shift = 1'b1;
          end
        end
        StRx: begin
          if (rise) begin
            rx_d      = {rx_q[44:0], mosi_s};
            cnt_d     = cnt_q + 7'd1;
            crc_shift = (cnt_q <= 7'd39);
            if (cnt_q == 7'd47) begin
              if (frame_w[46] && frame_w[0]) begin
                state_d = StNcr;
                cnt_d   = 7'd0;
                valid_d = 1'b1;
                index_d = frame_idx;
                arg_d   = frame_arg;
                idle_d  = ex_idle;
                polls_d = ex_polls;
                app_d   = ex_app;
                long_d  = ex_long;
                resp_d  = {ex_r1, ex_tail};
              end else begin
                state_d = StHunt;
              end
            end
          end
        end
        StNcr: begin
          if (fall) begin
            miso_d = 1'b1;
            if (cnt_q == 7'(NcrBits - 1)) begin
              state_d = StTx;
              cnt_d   = long_q ? 7'(RespLongBits) : 7'(RespR1Bits);
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        StTx: begin
          if (fall) begin
            if (cnt_q == 7'd0) begin
              miso_d  = 1'b1;
              state_d = StHunt;
            end else begin
              miso_d = resp_q[39];
              resp_d = {resp_q[38:0], 1'b0};
              cnt_d  = cnt_q - 7'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
      state_q     <= StHunt;
      cnt_q       <= 7'd0;
      rx_q        <= '0;
      resp_q      <= '0;
      long_q      <= 1'b0;
      idle_q      <= 1'b1;
      polls_q     <= 4'd0;
      app_q       <= 1'b0;
      miso_q      <= 1'b1;
      valid_q     <= 1'b0;
      index_q     <= 6'd0;
      arg_q       <= 32'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      resp_q      <= resp_d;
      long_q      <= long_d;
      idle_q      <= idle_d;
      polls_q     <= polls_d;
      app_q       <= app_d;
      miso_q      <= miso_d;
      valid_q     <= valid_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
    end
  end

  assign miso      = miso_q;
  assign in_idle   = idle_q;
  assign cmd_valid = valid_q;
  assign cmd_index = index_q;
  assign cmd_arg   = arg_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboard bench for sd_spi_responder: host-side SPI driver, card reference model, monitors.
module tb_sd_spi_responder;

  localparam int          NcrBytes  = 1;
  localparam int          InitPolls = 2;
  localparam logic [31:0] Ocr       = 32'h40FF8000;
  localparam int          Hp        = 5;
`ifdef SD_RESP_CRC_CHECK_EN
  localparam bit CrcOn = 1'b1;
`else
  localparam bit CrcOn = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b1;
  logic        miso, in_idle, cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [37:0] exp_cmd_q[$];
  logic [7:0]  got_byte;
  event        byte_ev;

  // Reference card state
  bit          m_idle = 1'b1;
  bit          m_app = 1'b0;
  int          m_polls = 0;

  sd_spi_responder #(
    .NCR_BYTES (NcrBytes),
    .INIT_POLLS(InitPolls),
    .OCR       (Ocr)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .in_idle  (in_idle),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .cmd_arg  (cmd_arg)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endfunction

  // CRC7 as the remainder of polynomial division by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic void model_cmd(input logic [5:0] idx, input logic [31:0] arg,
                                    input bit crc_ok, output bq_t resp);
    logic [31:0] tail;
    logic [31:0] ocr_v;
    bit          long_r;
    bit          illegal;
    ocr_v   = Ocr;
    tail    = 32'h0;
    long_r  = 1'b0;
    illegal = 1'b0;
    resp    = {};
    exp_cmd_q.push_back({idx, arg});
    if (!crc_ok && CrcOn) begin
      resp.push_back({4'b0000, 1'b1, 2'b00, m_idle});
      return;
    end
    if (idx == 6'd0) begin
      m_idle  = 1'b1;
      m_polls = 0;
    end else if (idx == 6'd8) begin
      long_r = 1'b1;
      tail   = {20'h0, arg[11:0]};
    end else if (idx == 6'd55) begin
      illegal = 1'b0;
    end else if (idx == 6'd41 && m_app) begin
      m_polls = (m_polls < 15) ? m_polls + 1 : 15;
      if (m_polls >= InitPolls) m_idle = 1'b0;
    end else if (idx == 6'd58) begin
      long_r = 1'b1;
      tail   = {~m_idle, ocr_v[30:0]};
    end else begin
      illegal = 1'b1;
    end
    m_app = (idx == 6'd55);
    resp.push_back({4'b0000, 1'b0, illegal, 1'b0, m_idle});
    if (long_r) begin
      for (int i = 3; i >= 0; i--) resp.push_back(tail[8*i +: 8]);
    end
  endfunction

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI mode 0: data set while sclk low, sampled on the rise.
  task automatic spi_xfer(input logic o, output logic i);
    mosi = o;
    idle_clks(Hp);
    sclk = 1'b1;
    i = miso;
    idle_clks(Hp);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [47:0] f, input int n);
    logic dummy;
    for (int k = 47; k > 47 - n; k--) spi_xfer(f[k], dummy);
  endtask

  task automatic read_byte();
    logic [7:0] b;
    logic       bit_in;
    for (int k = 7; k >= 0; k--) begin
      spi_xfer(1'b1, bit_in);
      b[k] = bit_in;
    end
    got_byte = b;
    ->byte_ev;
  endtask

  task automatic xact_raw(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    bq_t resp;
    model_cmd(idx, arg, crc == crc7({2'b01, idx, arg}), resp);
    for (int i = 0; i < NcrBytes; i++) exp_q.push_back(8'hFF);
    foreach (resp[i]) exp_q.push_back(resp[i]);
    cs_n = 1'b0;
    idle_clks(4);
    send_bits({2'b01, idx, arg, crc, 1'b1}, 48);
    repeat (NcrBytes + resp.size()) read_byte();
    cs_n = 1'b1;
    idle_clks(6);
    check("in_idle", in_idle, m_idle);
  endtask

  task automatic xact(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc);
    logic [6:0] crc;
    crc = crc7({2'b01, idx, arg});
    if (bad_crc) crc = crc ^ 7'($urandom_range(1, 127));
    xact_raw(idx, arg, crc);
  endtask

  // Malformed frame: transmission bit or end bit cleared; card must stay silent.
  task automatic xact_malformed(input bit kill_end);
    logic [47:0] f;
    f = {2'b01, 6'($urandom_range(0, 63)), 32'($urandom), 7'd0, 1'b1};
    if (kill_end) f[0] = 1'b0;
    else f[46] = 1'b0;
    for (int i = 0; i < NcrBytes + 1; i++) exp_q.push_back(8'hFF);
    cs_n = 1'b0;
    idle_clks(4);
    send_bits(f, 48);
    repeat (NcrBytes + 1) read_byte();
    cs_n = 1'b1;
    idle_clks(6);
  endtask

  always @(byte_ev) begin
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL miso_byte: got %02h, required no byte", got_byte);
    end else begin
      check("miso_byte", got_byte, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      if (exp_cmd_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL cmd_valid: got pulse idx %0d, required no pulse", cmd_index);
      end else begin
        logic [37:0] e;
        e = exp_cmd_q.pop_front();
        check("cmd_index", cmd_index, e[37:32]);
        check("cmd_arg", cmd_arg, e[31:0]);
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t  resp;
    logic bit_in;
    idle_clks(5);
    check("rst_miso", miso, 1'b1);
    check("rst_in_idle", in_idle, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_index", cmd_index, 6'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    rst = 1'b1;
    idle_clks(4);

    xact(6'd0, 32'h0, 1'b0);
    xact(6'd8, 32'h000001AA, 1'b0);
    xact_raw(6'd0, 32'h0, 7'd0);
    xact(6'd41, 32'h40000000, 1'b0);
    xact(6'd55, 32'h0, 1'b0);
    xact(6'd41, 32'h40000000, 1'b0);
    xact(6'd55, 32'h0, 1'b0);
    xact(6'd41, 32'h40000000, 1'b0);
    xact(6'd58, 32'h0, 1'b0);

    // Reset during the OCR bytes of a CMD58 response.
    model_cmd(6'd58, 32'h0, 1'b1, resp);
    for (int i = 0; i < NcrBytes; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(resp[0]);
    cs_n = 1'b0;
    idle_clks(4);
    send_bits({2'b01, 6'd58, 32'h0, crc7({2'b01, 6'd58, 32'h0}), 1'b1}, 48);
    repeat (NcrBytes + 1) read_byte();
    repeat (3) spi_xfer(1'b1, bit_in);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_miso", miso, 1'b1);
    check("midrst_in_idle", in_idle, 1'b1);
    check("midrst_cmd_index", cmd_index, 6'd0);
    check("midrst_cmd_arg", cmd_arg, 32'd0);
    cs_n = 1'b1;
    idle_clks(3);
    rst = 1'b1;
    m_idle  = 1'b1;
    m_polls = 0;
    m_app   = 1'b0;
    idle_clks(4);
    xact(6'd58, 32'h0, 1'b0);

    // Framing abort after 20 bits of CMD0.
    cs_n = 1'b0;
    idle_clks(4);
    send_bits({2'b01, 6'd0, 32'h0, 7'h4A, 1'b1}, 20);
    cs_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_miso", miso, 1'b1);
    end
    xact(6'd0, 32'h0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int          sel;
      logic [31:0] arg;
      sel = $urandom_range(0, 9);
      arg = $urandom;
      case (sel)
        0:       xact(6'd0, arg, 1'b0);
        1:       xact(6'd8, arg, 1'b0);
        2, 3:    xact(6'd55, arg, 1'b0);
        4, 5:    xact(6'd41, arg, 1'b0);
        6:       xact(6'd58, arg, 1'b0);
        7:       xact(6'($urandom_range(0, 63)), arg, 1'b0);
        8:       xact_malformed(1'($urandom_range(0, 1)));
        default: xact(6'd41, arg, 1'b1);
      endcase
    end

    idle_clks(10);
    check("exp_bytes_left", exp_q.size(), 0);
    check("exp_cmds_left", exp_cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
